// File: rtl/binary_pkg.sv
// Shared constants for the binary-to-pixel expander: pixel width, default
// foreground/background values and frame counter width.
package binary_pkg;

  localparam int PIXEL_W     = 8;
  localparam int FRAME_CNT_W = 16;

  localparam logic [PIXEL_W-1:0] FG_DEFAULT = 8'hFF;
  localparam logic [PIXEL_W-1:0] BG_DEFAULT = 8'h00;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Column/row position tracker with a wrapping completed-frame counter.
// Position advances once per accepted pixel; clear resets position only.
module pixel_position_counter
  import binary_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int COL_W      = cnt_width(IMG_WIDTH),
  parameter int ROW_W      = cnt_width(IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   clear,
  output logic [COL_W-1:0]       col,
  output logic [ROW_W-1:0]       row,
  output logic                   eof,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    frame_d = frame_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      frame_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign eof         = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign frame_count = frame_q;

endmodule

// File: rtl/binary_expand.sv
// Expands packed 1-bit pixels (MSB leftmost) into 8-bit FG/BG pixels with
// valid/ready handshakes and frame markers; one pixel per cycle sustained.
module binary_expand
  import binary_pkg::*;
#(
  parameter int                 IMG_WIDTH  = 64,
  parameter int                 IMG_HEIGHT = 64,
  parameter logic [PIXEL_W-1:0] FG_VAL     = FG_DEFAULT,
  parameter logic [PIXEL_W-1:0] BG_VAL     = BG_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_clear,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [PIXEL_W-1:0]     pixel_out,
  output logic                   pixel_valid,
  input  logic                   pixel_ready,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bits_left_q, bits_left_d;
  logic             byte_xfer, pixel_xfer;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             pos_eof;

  assign pixel_valid = (bits_left_q != 4'd0);
  // Accepting on the last buffered bit lets the next byte follow with no bubble.
  assign byte_ready  = !soft_clear &&
                       ((bits_left_q == 4'd0) || ((bits_left_q == 4'd1) && pixel_ready));
  assign byte_xfer   = byte_valid && byte_ready;
  assign pixel_xfer  = pixel_valid && pixel_ready && !soft_clear;

  always_comb begin
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    if (soft_clear) begin
      shift_d     = '0;
      bits_left_d = '0;
    end else if (byte_xfer) begin
      shift_d     = byte_in;
      bits_left_d = 4'd8;
    end else if (pixel_xfer) begin
      shift_d     = {shift_q[6:0], 1'b0};
      bits_left_d = bits_left_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      bits_left_q <= '0;
    end else begin
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
    end
  end

  pixel_position_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .advance     (pixel_xfer),
    .clear       (soft_clear),
    .col         (col),
    .row         (row),
    .eof         (pos_eof),
    .frame_count (frame_count)
  );

  assign pixel_out = shift_q[7] ? FG_VAL : BG_VAL;
  assign sof       = pixel_valid && (col == '0) && (row == '0);
  assign eol       = pixel_valid && (col == COL_LAST);
  assign eof       = pixel_valid && pos_eof;

endmodule

// File: doc/binary_expand.md
BINARY_EXPAND -- requirements
Module: binary_expand

Interface
REQ-001 SHALL provide parameter IMG_WIDTH, default 64, pixels per line; multiple of 8, minimum 8.
REQ-002 SHALL provide parameter IMG_HEIGHT, default 64, lines per frame, minimum 1.
REQ-003 SHALL provide parameter FG_VAL, default 8'hFF, pixel value emitted for bit 1.
REQ-004 SHALL provide parameter BG_VAL, default 8'h00, pixel value emitted for bit 0.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; reset is asynchronous and active-high.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 soft_clear  in  1  synchronous flush of buffered bits and position counters.
REQ-008 byte_in  in  8  packed binary pixels; MSB is the leftmost pixel.
REQ-009 byte_valid  in  1  byte_in is valid.
REQ-010 byte_ready  out  1  block accepts byte_in this cycle.
REQ-011 pixel_out  out  8  expanded pixel, FG_VAL or BG_VAL.
REQ-012 pixel_valid  out  1  pixel_out is valid.
REQ-013 pixel_ready  in  1  downstream accepts pixel_out.
REQ-014 sof / eol / eof  out  1 each  start-of-frame, end-of-line and end-of-frame markers, qualified by pixel_valid.
REQ-015 frame_count  out  16  count of completed frames, wraps at 16'hFFFF to 0.

Function
REQ-016 Byte transfer SHALL occur on a rising clk edge with byte_valid && byte_ready; pixel transfer SHALL occur with pixel_valid && pixel_ready.
REQ-017 State: 8-bit shift register plus bits_left counter (0..8); pixel_valid = (bits_left != 0).
REQ-018 pixel_out SHALL be FG_VAL when shift register bit 7 = 1, else BG_VAL; it SHALL stay stable while pixel_valid && !pixel_ready.
REQ-019 byte_ready = !soft_clear && (bits_left == 0 || (bits_left == 1 && pixel_ready)).
REQ-020 On byte transfer: shift register <= byte_in, bits_left <= 8, regardless of any simultaneous last-pixel transfer.
REQ-021 On pixel transfer without byte transfer: shift register shifts left by 1, bits_left decrements.
REQ-022 Latency: byte accepted at edge N gives its first pixel valid after edge N; sustained throughput SHALL be 1 pixel/cycle with no bubble between bytes.
REQ-023 Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on pixel transfer.
REQ-024 col SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-025 sof = pixel_valid && col==0 && row==0; eol = pixel_valid && col==IMG_WIDTH-1; eof = eol && row==IMG_HEIGHT-1.
REQ-026 frame_count SHALL increment on the pixel transfer where eof is high.
REQ-027 soft_clear SHALL, on its edge, set bits_left, col and row to 0 and discard buffered bits; frame_count SHALL be preserved.
REQ-028 soft_clear SHALL take precedence over simultaneous byte_valid and pixel_ready; no transfer of either kind completes that cycle.
REQ-029 With byte_valid low and buffer empty, pixel_valid SHALL be 0 and all counters SHALL hold.

Reset
REQ-030 rst high SHALL immediately clear bits_left, shift register, col, row and frame_count to 0, independent of clk.
REQ-031 During and after reset: pixel_valid=0, sof=eol=eof=0, pixel_out=BG_VAL, byte_ready=1 once rst deasserts and soft_clear is low.
REQ-032 Reset mid-line or mid-byte SHALL discard partial data; the next accepted byte SHALL start at col 0, row 0.

Structure
REQ-033 Shared package binary_pkg SHALL hold PIXEL_W=8, FG/BG default constants and FRAME_CNT_W=16.
REQ-034 Position/frame counting SHALL be one sub-module, pixel_position_counter (inputs: advance, clear; outputs: col, row, eof, frame_count).
REQ-035 Byte buffer and handshake SHALL reside in the top module.

Verification
REQ-036 Byte 8'hA5, pixel_ready=1 -> 8 consecutive pixels FF,00,FF,00,00,FF,00,FF, then pixel_valid=0.
REQ-037 Continuous bytes 8'hFF,8'h00 with pixel_ready=1 -> 16 pixels with no gap, byte_ready high on cycles where bits_left==1.
REQ-038 pixel_ready toggled 1,0,1,0 on byte 8'h80 -> pixel_out held during stalls, no pixel lost or duplicated.
REQ-039 IMG_WIDTH=8, IMG_HEIGHT=2, 2 bytes streamed twice -> eol on pixels 8 and 16, eof and frame_count 0->1->2 on pixels 16 and 32, sof on pixels 1 and 17.
REQ-040 soft_clear after 3 pixels of byte 8'hF0 with byte_valid high -> byte not accepted that cycle, pixel_valid=0, next pixel has sof=1, frame_count unchanged.
REQ-041 rst asserted mid-frame asynchronously between edges -> pixel_valid, counters and frame_count read 0 before the next edge.
